mult_div_ctrl: RTL and testbench

//  Sequential controller for the HI/LO register pair of the multicycle MIPS core.

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/mult_div_core.sv | 91 +++++++++
 rtl/mult_div_ctrl.sv | 123 ++++++++++++
 tb/tb_mult_div_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types for the HI/LO multiply/divide controller: FSM states, operation type
// and the iteration-counter width.
package mult_div_pkg;

  localparam int MD_WIDTH = 32;
  localparam int ITER_W   = $clog2(MD_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_WRITE
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/mult_div_core.sv
// Iterative radix-2 datapath: unsigned shift-add multiply or restoring divide on operand
// magnitudes, followed by a sign-fix step. Sequenced by load/step/fix strobes from the FSM.
module mult_div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // r_hi: product high half / remainder; r_lo: multiplier->product low / dividend->quotient
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opb;
  op_t                r_op;
  logic               r_s_res;
  logic               r_s_rem;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_abs_a    = i_op_a[WIDTH-1] ? -i_op_a : i_op_a;
  assign w_abs_b    = i_op_b[WIDTH-1] ? -i_op_b : i_op_b;
  assign w_addend   = r_lo[0] ? r_opb : '0;
  assign w_sum      = {1'b0, r_hi} + {1'b0, w_addend};
  assign w_shift    = {r_hi, r_lo[WIDTH-1]};
  // Borrow in the top bit means the shifted remainder is smaller than the divisor
  assign w_diff     = w_shift - {1'b0, r_opb};
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_s_res ? -w_prod : w_prod;
  assign w_quo_fix  = r_s_res ? -r_lo : r_lo;
  assign w_rem_fix  = r_s_rem ? -r_hi : r_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_op    <= OP_MULT;
      r_s_res <= 1'b0;
      r_s_rem <= 1'b0;
    end else if (i_load) begin
      r_hi    <= '0;
      r_lo    <= w_abs_a;
      r_opb   <= w_abs_b;
      r_op    <= i_op;
      r_s_res <= i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1];
      r_s_rem <= i_op_a[WIDTH-1];
    end else if (i_step) begin
      if (r_op == OP_MULT) begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end else if (!w_diff[WIDTH]) begin
        r_hi <= w_diff[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        r_hi <= w_shift[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
      end
    end else if (i_fix) begin
      if (r_op == OP_MULT) begin
        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
        r_lo <= w_prod_fix[WIDTH-1:0];
      end else begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_ctrl.sv
// HI/LO multiply/divide controller: accepts start strobes, sequences the iterative core
// and commits the signed 64-bit result to the HI/LO pair with one-cycle write pulses.
//
//  state   | meaning
//  S_IDLE  | waiting for start_mult / start_div
//  S_MULT  | one multiply iteration per cycle, WIDTH cycles
//  S_DIV   | one quotient bit per cycle, WIDTH cycles
//  S_FIX   | apply result / remainder signs
//  S_WRITE | done pulse; HI/LO write unless divide-by-zero
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata,
  output logic             hi_write,
  output logic             lo_write
);

  state_t              r_state;
  state_t              w_next;
  logic [ITER_W-1:0]   r_cnt;
  logic                r_dbz;
  logic [WIDTH-1:0]    r_hi_last;
  logic [WIDTH-1:0]    r_lo_last;
  logic                w_accept;
  logic                w_load;
  logic                w_step;
  logic                w_fix;
  logic                w_commit;
  op_t                 w_op;
  logic [WIDTH-1:0]    w_core_hi;
  logic [WIDTH-1:0]    w_core_lo;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_fix    = 1'b0;
    w_op     = OP_MULT;
    case (r_state)
      S_IDLE: begin
        if (start_mult) begin
          w_accept = 1'b1;
          w_load   = 1'b1;
          w_next   = S_MULT;
        end else if (start_div) begin
          w_accept = 1'b1;
          w_op     = OP_DIV;
          // A zero divisor skips the datapath entirely and reports in cycle 1
          if (op_b == '0) begin
            w_next = S_WRITE;
          end else begin
            w_load = 1'b1;
            w_next = S_DIV;
          end
        end
      end
      S_MULT, S_DIV: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        w_fix  = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
      r_hi_last <= '0;
      r_lo_last <= '0;
    end else begin
      r_state   <= w_next;
      r_hi_last <= hi_wdata;
      r_lo_last <= lo_wdata;
      if (w_load) r_cnt <= ITER_W'(WIDTH - 1);
      else if (w_step) r_cnt <= r_cnt - ITER_W'(1);
      if (w_accept) r_dbz <= (w_next == S_WRITE);
    end
  end

  mult_div_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_fix  (w_fix),
    .i_op   (w_op),
    .i_op_a (op_a),
    .i_op_b (op_b),
    .o_hi   (w_core_hi),
    .o_lo   (w_core_lo)
  );

  // Write data follows the core only while committing, otherwise it holds
  assign w_commit    = (r_state == S_WRITE) && !r_dbz;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_WRITE);
  assign div_by_zero = r_dbz;
  assign hi_write    = w_commit;
  assign lo_write    = w_commit;
  assign hi_wdata    = w_commit ? w_core_hi : r_hi_last;
  assign lo_wdata    = w_commit ? w_core_lo : r_lo_last;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed vector bench for mult_div_ctrl: table of signed MULT/DIV cases plus
// hand-written busy-start, reset-abort and reset-state sequences.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_by_zero, hi_write, lo_write;
  logic [31:0] hi_wdata, lo_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi_wdata    (hi_wdata),
    .lo_wdata    (lo_wdata),
    .hi_write    (hi_write),
    .lo_write    (lo_write)
  );

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        wr;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Launch one operation and observe 40 cycles after the accept edge.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dbz, output logic wr, output int bad, output int ndone);
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(posedge clk);
    lat = -1; hi = '0; lo = '0; dbz = 1'b0; wr = 1'b0; bad = 0; ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_mult = 1'b0;
        start_div  = 1'b0;
      end
      if (k == inj) begin
        start_div = 1'b1;
        op_b      = '0;
      end
      if (k == inj + 1) start_div = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          hi  = hi_wdata;
          lo  = lo_wdata;
          dbz = div_by_zero;
          wr  = hi_write;
          if (lo_write !== hi_write) bad++;
        end
      end else if (hi_write || lo_write) begin
        bad++;
      end
      if (lat < 0 || k == lat) begin
        if (busy !== 1'b1) bad++;
      end else if (busy !== 1'b0) begin
        bad++;
      end
    end
  endtask

  initial begin
    int          lat, bad, ndone, errs;
    logic [31:0] hi, lo;
    logic        dbz, wr;

    tv[0]  = '{1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1};
    tv[1]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1};
    tv[2]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000,  1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 32'h0000_0005, 32'h0000_0006, 34, 32'h0000_0000, 32'h0000_001E, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 34, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000,  1, 32'hFFFF_FFFE, 32'h0000_000E, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 34, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000, 34, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    tv[12] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, div_by_zero, hi_write, lo_write}, 5'b0);
    chk("rst_wdata", {hi_wdata, lo_wdata}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    for (int i = 0; i < 13; i++) begin
      run_op(tv[i].m, tv[i].d, tv[i].a, tv[i].b, 0, lat, hi, lo, dbz, wr, bad, ndone);
      chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("v%0d_hi", i), hi, tv[i].hi);
      chk($sformatf("v%0d_lo", i), lo, tv[i].lo);
      chk($sformatf("v%0d_dbz", i), dbz, tv[i].dbz);
      chk($sformatf("v%0d_write", i), wr, tv[i].wr);
      chk($sformatf("v%0d_busy_pulse_errs", i), bad, 0);
      chk($sformatf("v%0d_done_count", i), ndone, 1);
    end

    // start_div arriving mid-multiply is dropped
    run_op(1'b1, 1'b0, 32'd9, 32'd9, 10, lat, hi, lo, dbz, wr, bad, ndone);
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_latency", lat, 34);
    chk("busy_start_lo", lo, 32'd81);
    chk("busy_start_hi", hi, 32'd0);
    chk("busy_start_dbz", dbz, 1'b0);
    chk("busy_start_errs", bad, 0);

    // Reset at cycle 10 of a multiply aborts it without any write
    @(negedge clk);
    start_mult = 1'b1; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("reset_abort_busy", busy, 1'b0);
    chk("reset_abort_write", {done, hi_write, lo_write}, 3'b0);
    @(negedge clk);
    reset = 1'b0;
    errs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || done || hi_write || lo_write) errs++;
    end
    chk("post_reset_quiet", errs, 0);
    chk("post_reset_wdata", {hi_wdata, lo_wdata}, 64'h0);

    run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, lat, hi, lo, dbz, wr, bad, ndone);
    chk("fresh_latency", lat, 34);
    chk("fresh_lo", lo, 32'd12);
    chk("fresh_hi", hi, 32'd0);
    chk("fresh_write", wr, 1'b1);
    chk("fresh_errs", bad, 0);
    chk("fresh_hold_lo", lo_wdata, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
